// File: rtl/jogo_sequencia_param.sv
// Simon-style sequence game engine.
// Fills a sequence memory from a 16-bit LFSR, replays a growing prefix on the LEDs and checks
// the player's presses. Each move has a timeout.
// Ports:
//   clock, reset     - system clock; synchronous active-high reset
//   iniciar          - start/restart request (level), honoured in INICIAL and terminal states
//   modo             - 0: LFSR reloaded with SEMENTE at each start; 1: LFSR free-runs
//   dificuldade      - game length select, latched on start
//   botoes           - debounced active-high buttons
//   leds             - one-hot sequence display, or button echo while waiting for input
//   pronto           - any terminal state
//   ganhou/perdeu/timeout - win / wrong press / move timeout flags
//   rodada           - current round length
//   db_estado        - state code
module jogo_sequencia_param #(
  parameter int unsigned N_BOTOES = 4,
  parameter int unsigned PROF_MAX = 16,
  parameter int unsigned T_LED    = 1000,
  parameter int unsigned T_PAUSA  = 250,
  parameter int unsigned T_JOGADA = 5000,
  parameter logic [15:0] SEMENTE  = 16'hACE1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      iniciar,
  input  logic                      modo,
  input  logic [1:0]                dificuldade,
  input  logic [N_BOTOES-1:0]       botoes,
  output logic [N_BOTOES-1:0]       leds,
  output logic                      pronto,
  output logic                      ganhou,
  output logic                      perdeu,
  output logic                      timeout,
  output logic [$clog2(PROF_MAX):0] rodada,
  output logic [3:0]                db_estado
);

  localparam int unsigned SymW = $clog2(N_BOTOES);
  localparam int unsigned IdxW = $clog2(PROF_MAX);
  localparam int unsigned RodW = IdxW + 1;
  localparam int unsigned TMax = (T_LED > T_PAUSA) ?
                                 ((T_LED > T_JOGADA) ? T_LED : T_JOGADA) :
                                 ((T_PAUSA > T_JOGADA) ? T_PAUSA : T_JOGADA);
  localparam int unsigned TimW = $clog2(TMax + 1);
  localparam logic [15:0] Seed = (SEMENTE == 16'd0) ? 16'd1 : SEMENTE;
  localparam logic [N_BOTOES-1:0] One = {{(N_BOTOES-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    StInicial  = 4'd0,
    StGera     = 4'd1,
    StMostra   = 4'd2,
    StPausa    = 4'd3,
    StEspera   = 4'd4,
    StSolta    = 4'd5,
    StGanhou   = 4'd6,
    StErro     = 4'd7,
    StEstourou = 4'd8
  } estadoT;

  estadoT              estadoQ, estadoD;
  logic [15:0]         lfsrQ, lfsrD, lfsrStep;
  logic [SymW-1:0]     memQ [PROF_MAX];
  logic [SymW-1:0]     sym;
  logic                memWe;
  logic [IdxW-1:0]     iQ, iD;
  logic [RodW-1:0]     kQ, kD, kInc;
  logic [RodW-1:0]     rodadaQ, rodadaD;
  logic [RodW-1:0]     compQ, compD;
  logic [TimW-1:0]     timerQ, timerD;
  logic [N_BOTOES-1:0] ledsQ, ledsD;
  logic [N_BOTOES-1:0] alvo;
  logic                iniciarJogo;

  // Fibonacci LFSR, taps 16,14,13,11 (bits 0,2,3,5 in shift-right form).
  assign lfsrStep = {lfsrQ[0] ^ lfsrQ[2] ^ lfsrQ[3] ^ lfsrQ[5], lfsrQ[15:1]};
  assign sym      = SymW'(lfsrQ[7:0] % 8'(N_BOTOES));
  assign kInc     = kQ + RodW'(1);
  assign alvo     = One << memQ[kQ[IdxW-1:0]];

  always_comb begin
    estadoD     = estadoQ;
    lfsrD       = modo ? lfsrStep : lfsrQ;
    memWe       = 1'b0;
    iD          = iQ;
    kD          = kQ;
    rodadaD     = rodadaQ;
    compD       = compQ;
    timerD      = timerQ;
    iniciarJogo = 1'b0;

    case (estadoQ)
      StInicial: iniciarJogo = iniciar;
      StGera: begin
        memWe = 1'b1;
        if (!modo) lfsrD = lfsrStep;
        iD = iQ + IdxW'(1);
        if (iQ == IdxW'(PROF_MAX - 1)) begin
          rodadaD = RodW'(1);
          kD      = '0;
          timerD  = '0;
          estadoD = StMostra;
        end
      end
      StMostra: begin
        if (timerQ == TimW'(T_LED - 1)) begin
          timerD  = '0;
          estadoD = StPausa;
        end else begin
          timerD = timerQ + TimW'(1);
        end
      end
      StPausa: begin
        if (timerQ == TimW'(T_PAUSA - 1)) begin
          timerD = '0;
          if (kInc == rodadaQ) begin
            kD      = '0;
            estadoD = StEspera;
          end else begin
            kD      = kInc;
            estadoD = StMostra;
          end
        end else begin
          timerD = timerQ + TimW'(1);
        end
      end
      StEspera: begin
        // A press in the expiry cycle takes precedence over the timeout.
        if (botoes != '0) begin
          estadoD = (botoes == alvo) ? StSolta : StErro;
        end else if (timerQ >= TimW'(T_JOGADA - 1)) begin
          estadoD = StEstourou;
        end
        if (timerQ < TimW'(T_JOGADA)) timerD = timerQ + TimW'(1);
      end
      StSolta: begin
        if (botoes == '0) begin
          if (kInc < rodadaQ) begin
            kD      = kInc;
            timerD  = '0;
            estadoD = StEspera;
          end else if (rodadaQ == compQ) begin
            estadoD = StGanhou;
          end else begin
            rodadaD = rodadaQ + RodW'(1);
            kD      = '0;
            timerD  = '0;
            estadoD = StMostra;
          end
        end
      end
      StGanhou, StErro, StEstourou: iniciarJogo = iniciar;
      default: estadoD = StInicial;
    endcase

    if (iniciarJogo) begin
      estadoD = StGera;
      iD      = '0;
      if (!modo) lfsrD = Seed;
      case (dificuldade)
        2'd0:    compD = RodW'(PROF_MAX / 4);
        2'd1:    compD = RodW'(PROF_MAX / 2);
        default: compD = RodW'(PROF_MAX);
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with db_estado.
  always_comb begin
    ledsD = '0;
    case (estadoD)
      StMostra:          ledsD = One << memQ[kD[IdxW-1:0]];
      StEspera, StSolta: ledsD = botoes;
      default:           ledsD = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estadoQ <= StInicial;
      lfsrQ   <= Seed;
      iQ      <= '0;
      kQ      <= '0;
      rodadaQ <= '0;
      compQ   <= '0;
      timerQ  <= '0;
      ledsQ   <= '0;
      pronto  <= 1'b0;
      ganhou  <= 1'b0;
      perdeu  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      estadoQ <= estadoD;
      lfsrQ   <= lfsrD;
      iQ      <= iD;
      kQ      <= kD;
      rodadaQ <= rodadaD;
      compQ   <= compD;
      timerQ  <= timerD;
      ledsQ   <= ledsD;
      pronto  <= (estadoD == StGanhou) || (estadoD == StErro) || (estadoD == StEstourou);
      ganhou  <= (estadoD == StGanhou);
      perdeu  <= (estadoD == StErro);
      timeout <= (estadoD == StEstourou);
    end
  end

  always_ff @(posedge clock) begin
    if (memWe) memQ[iQ] <= sym;
  end

  assign leds      = ledsQ;
  assign rodada    = rodadaQ;
  assign db_estado = estadoQ;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
module tb_jogo_sequencia_param;

  localparam int unsigned NB = 4;
  localparam int unsigned PM = 8;
  localparam int unsigned TL = 4;
  localparam int unsigned TP = 2;
  localparam int unsigned TJ = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          iniciar = 1'b0;
  logic          modo = 1'b0;
  logic [1:0]    dificuldade = 2'd0;
  logic [NB-1:0] botoes = '0;
  logic [NB-1:0] leds;
  logic          pronto, ganhou, perdeu, timeout;
  logic [3:0]    rodada;
  logic [3:0]    db_estado;

  int total = 0;
  int bad = 0;
  int seq[PM];

  jogo_sequencia_param #(
    .N_BOTOES(NB), .PROF_MAX(PM), .T_LED(TL), .T_PAUSA(TP), .T_JOGADA(TJ), .SEMENTE(16'hACE1)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo), .dificuldade(dificuldade),
    .botoes(botoes), .leds(leds), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
    .timeout(timeout), .rodada(rodada), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Reference LFSR: shift right, feedback from bits 0,2,3,5.
  function automatic logic [15:0] stepRef(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic int symAt(input int n);
    logic [15:0] l;
    l = 16'hACE1;
    for (int j = 0; j < n; j++) l = stepRef(l);
    return int'(l[7:0]) % NB;
  endfunction

  function automatic logic [NB-1:0] oneHot(input int s);
    logic [NB-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pulse iniciar, check GERA for PROF_MAX cycles, land on the first MOSTRA cycle.
  task automatic startGame();
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    chk("gera_entry", 32'(db_estado), 32'd1);
    chk("gera_flags", {pronto, ganhou, perdeu, timeout}, 4'b0000);
    repeat (PM - 1) step();
    chk("gera_last", 32'(db_estado), 32'd1);
    step();
  endtask

  // From the first MOSTRA cycle of a round, check the replay and landing in ESPERA.
  task automatic showRound(input int r);
    for (int j = 0; j < r; j++) begin
      chk("mostra_state", 32'(db_estado), 32'd2);
      chk("mostra_leds", 32'(leds), 32'(oneHot(seq[j])));
      repeat (TL - 1) step();
      chk("mostra_leds_end", 32'(leds), 32'(oneHot(seq[j])));
      step();
      chk("pausa_state", 32'(db_estado), 32'd3);
      chk("pausa_leds", 32'(leds), 32'd0);
      repeat (TP) step();
    end
    chk("espera_state", 32'(db_estado), 32'd4);
    chk("espera_rodada", 32'(rodada), 32'(r));
  endtask

  task automatic pressOk(input logic [NB-1:0] b);
    botoes = b;
    step();
    chk("solta_state", 32'(db_estado), 32'd5);
    chk("solta_echo", 32'(leds), 32'(b));
    botoes = '0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int j = 0; j < PM; j++) seq[j] = symAt(j);

    repeat (2) step();
    reset = 1'b0;
    chk("reset_state", 32'(db_estado), 32'd0);
    chk("reset_outs", {leds, pronto, ganhou, perdeu, timeout, rodada}, 32'd0);

    // Perfect game, comp = 2.
    startGame();
    showRound(1);
    pressOk(oneHot(seq[0]));
    chk("r2_state", 32'(db_estado), 32'd2);
    chk("r2_rodada", 32'(rodada), 32'd2);
    showRound(2);
    pressOk(oneHot(seq[0]));
    chk("r2_next_move", 32'(db_estado), 32'd4);
    pressOk(oneHot(seq[1]));
    chk("win_state", 32'(db_estado), 32'd6);
    chk("win_flags", {pronto, ganhou, perdeu, timeout}, 4'b1100);
    chk("win_leds", 32'(leds), 32'd0);
    chk("win_rodada", 32'(rodada), 32'd2);
    step();
    chk("win_hold", 32'(ganhou), 32'd1);

    // Restart replays the same sequence, then a wrong single press.
    startGame();
    showRound(1);
    botoes = oneHot((seq[0] + 1) % NB);
    step();
    botoes = '0;
    chk("wrong_state", 32'(db_estado), 32'd7);
    chk("wrong_flags", {pronto, ganhou, perdeu, timeout}, 4'b1010);
    chk("wrong_leds", 32'(leds), 32'd0);

    // Two buttons at once, one of them correct.
    startGame();
    showRound(1);
    botoes = oneHot(seq[0]) | oneHot((seq[0] + 1) % NB);
    step();
    botoes = '0;
    chk("double_state", 32'(db_estado), 32'd7);
    chk("double_perdeu", 32'(perdeu), 32'd1);

    // Timeout after TJ idle cycles.
    startGame();
    showRound(1);
    repeat (TJ - 1) step();
    chk("to_cycle10", 32'(db_estado), 32'd4);
    step();
    chk("to_state", 32'(db_estado), 32'd8);
    chk("to_flags", {pronto, ganhou, perdeu, timeout}, 4'b1001);

    // Press exactly on the last allowed cycle wins over the timeout.
    startGame();
    showRound(1);
    repeat (TJ - 1) step();
    botoes = oneHot(seq[0]);
    step();
    chk("late_state", 32'(db_estado), 32'd5);
    chk("late_timeout", 32'(timeout), 32'd0);
    botoes = '0;
    step();
    chk("late_r2", 32'(db_estado), 32'd2);
    chk("late_r2_rodada", 32'(rodada), 32'd2);

    // Reset in the middle of round-2 display.
    step();
    reset = 1'b1;
    step();
    chk("midreset_state", 32'(db_estado), 32'd0);
    chk("midreset_outs", {leds, pronto, ganhou, perdeu, timeout, rodada}, 32'd0);

    // modo=1: LFSR runs from reset. Reset edge loads seed, 3 idle edges plus the start edge
    // advance it 4 times before the first GERA write.
    modo = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();
    for (int j = 0; j < PM; j++) seq[j] = symAt(j + 4);
    chk("modo1_differs", 32'(seq[0] != symAt(0)), 32'd1);
    startGame();
    showRound(1);
    pressOk(oneHot(seq[0]));
    showRound(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jogo_sequencia_param.md
Name: jogo_sequencia_param

Overview:
- Self-contained, parametrised Simon-style game engine: generates a pseudo-random sequence, replays it round by round on the LEDs and checks player button presses, with a per-move timeout.
- Generalises the fixed 4-button game datapath/control pair to N buttons, configurable sequence depth, three difficulty lengths and seeded or free-running sequence generation.
- Sits under the game top level and drives the LED/matrix front end plus the debug displays.

Parameters:
- N_BOTOES, 4: number of buttons and LEDs, legal range 2..16.
- PROF_MAX, 16: maximum sequence length, a power of 2, minimum 4.
- T_LED, 1000: clock cycles each sequence LED is lit.
- T_PAUSA, 250: dark clock cycles after each shown LED.
- T_JOGADA, 5000: clock cycles allowed per move before timeout.
- SEMENTE, 16'hACE1: LFSR seed. A value of 0 is replaced by 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- iniciar  in  1  start or restart request, level-sampled.
- modo  in  1  0 = LFSR reloaded with SEMENTE at each start (repeatable game); 1 = LFSR free-runs from reset and is not reloaded.
- dificuldade  in  2  game length: 0 = PROF_MAX/4, 1 = PROF_MAX/2, 2 or 3 = PROF_MAX. Latched on start.
- botoes  in  N_BOTOES  active-high buttons, already synchronised and debounced.
- leds  out  N_BOTOES  one-hot sequence display, or button echo while waiting for input.
- pronto  out  1  high in any terminal state.
- ganhou  out  1  win flag.
- perdeu  out  1  wrong-press flag.
- timeout  out  1  move-timeout flag.
- rodada  out  $clog2(PROF_MAX)+1  current round length.
- db_estado  out  4  state code.

Behaviour:
- Decided interface fact: one clock (clock); reset is synchronous and active-high (reset).
- Reset, taking priority over everything including mid-game: state INICIAL; leds, pronto, ganhou, perdeu, timeout and rodada all 0; LFSR = SEMENTE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in modo=1. In modo=0 it advances only in GERA.
- Symbol: sym = lfsr[7:0] % N_BOTOES. The internal memory holds PROF_MAX × $clog2(N_BOTOES) bits.
- Indices: k is the position index within the round; comp is the latched game length.
- States (db_estado code):
  - INICIAL(0): leds=0. iniciar=1 -> GERA. On that transition: latch comp from dificuldade; if modo=0, load LFSR with SEMENTE; clear flags; i=0.
  - GERA(1): each cycle write mem[i]=sym, i++. Takes exactly PROF_MAX cycles. Then rodada=1, k=0, -> MOSTRA.
  - MOSTRA(2): leds=onehot(mem[k]) for exactly T_LED cycles, then -> PAUSA.
  - PAUSA(3): leds=0 for exactly T_PAUSA cycles, then k++.
    - If k==rodada: k=0, timer=0, -> ESPERA.
    - Otherwise -> MOSTRA.
  - ESPERA(4): leds=botoes and the timer counts.
    - botoes!=0 and equal to onehot(mem[k]) -> SOLTA.
    - Any other nonzero value (wrong button, or more than one bit set) -> ERRO.
    - T_JOGADA cycles elapsed with botoes==0 -> ESTOUROU.
    - If a press and timer expiry occur in the same cycle, the press wins.
  - SOLTA(5): leds=botoes; timer holds. When botoes==0, k++ and:
    - If k<rodada: timer=0, -> ESPERA.
    - Else if rodada==comp -> GANHOU.
    - Else rodada++, k=0, -> MOSTRA.
  - GANHOU(6): ganhou=1.
  - ERRO(7): perdeu=1.
  - ESTOUROU(8): timeout=1.
- Terminal states (GANHOU, ERRO, ESTOUROU): pronto=1; leds=0; the flag is held. iniciar=1 -> GERA with the same actions as INICIAL->GERA. Flags fall in the cycle GERA is entered.
- iniciar is ignored in all non-terminal, non-INICIAL states.
- All outputs are registered (one cycle after the state change). Unused db_estado codes 9..15 are never produced; any illegal state -> INICIAL.
- Counters must not wrap: the timer saturates at T_JOGADA, and rodada never exceeds comp.

Test Plan:
- Common bench settings: N_BOTOES=4, PROF_MAX=8, T_LED=4, T_PAUSA=2, T_JOGADA=10, modo=0, dificuldade=0 (comp=2). The bench reference model computes the LFSR sequence.
- Start: iniciar pulse -> GERA lasts 8 cycles -> leds=onehot(mem[0]) for 4 cycles, 0 for 2 cycles, then ESPERA with db_estado=4 and rodada=1.
- Perfect game: correct presses with release each round -> rodada goes 1->2 -> ganhou=1, pronto=1, db_estado=6, leds=0.
- Wrong press: in round 1 press a non-matching button, or two buttons at once -> next state ERRO, perdeu=1, ganhou=0.
- Timeout: no press for 10 cycles in ESPERA -> timeout=1, db_estado=8. A press exactly on cycle 10 -> SOLTA, no timeout.
- Restart and determinism: iniciar from GANHOU with modo=0 -> flags clear and the identical sequence replays. With modo=1 and a different start cycle -> the sequence differs.
- Reset mid-MOSTRA (round 2) -> next cycle state 0, leds=0, rodada=0, all flags 0.
